// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with parametrised width, depth and flag levels.
// Occupancy is held in a separate counter; all flags are decoded from it.
module sync_fifo_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q,  count_d;
  logic [DATA_W-1:0] dout_q,   dout_d;
  logic              ovf_q,    ovf_d;
  logic              unf_q,    unf_d;

  logic full_s, empty_s;
  logic wr_ok, rd_ok;

  assign full_s  = (count_q == CW'(DEPTH));
  assign empty_s = (count_q == '0);

  // A full FIFO still takes a write when a read frees a slot this edge.
  assign wr_ok = wr && (!full_s || rd);
  assign rd_ok = rd && !empty_s;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem_q[rd_ptr_q];
    end
    count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
    if (wr && !wr_ok) ovf_d = 1'b1;
    if (rd && !rd_ok) unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout         = dout_q;
  assign count        = count_q;
  assign empty        = empty_s;
  assign full         = full_s;
  assign almost_full  = (count_q >= CW'(AF_LVL));
  assign almost_empty = (count_q <= CW'(AE_LVL));
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param at DATA_W=8, DEPTH=16.
// Inputs change and outputs are sampled 1 time unit after posedge.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr  = 1'b0;
  logic       rd  = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       empty, full, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_W(8),
    .DEPTH (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr          (wr),
    .rd          (rd),
    .din         (din),
    .dout        (dout),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h",
                tag, obs, exp);
  endtask

  task automatic cyc(input logic w,
                     input logic r,
                     input logic [7:0] d);
    wr  = w;
    rd  = r;
    din = d;
    @(posedge clk);
    #1;
    wr  = 1'b0;
    rd  = 1'b0;
  endtask

  task automatic flags(input string tag,
                       input int c);
    chk({tag, "_cnt"}, int'(count), c);
    chk({tag, "_emp"}, int'(empty), int'(c == 0));
    chk({tag, "_ful"}, int'(full), int'(c == 16));
    chk({tag, "_af"}, int'(almost_full), int'(c >= 14));
    chk({tag, "_ae"}, int'(almost_empty), int'(c <= 2));
  endtask

  initial begin
    // 1: reset
    rst = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    flags("rst", 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_unf", int'(underflow), 0);

    // 2: fill 0x00..0x0F, then one dropped write
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      flags("fill", i + 1);
    end
    chk("fill_ovf0", int'(overflow), 0);
    cyc(1'b1, 1'b0, 8'hAA);
    chk("drop_ovf", int'(overflow), 1);
    flags("drop", 16);

    // 3: drain, then one dropped read
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk("drain_dout", int'(dout), i);
      flags("drain", 15 - i);
    end
    chk("drain_unf0", int'(underflow), 0);
    cyc(1'b0, 1'b1, 8'h00);
    chk("udr_unf", int'(underflow), 1);
    chk("udr_dout", int'(dout), 8'h0F);
    flags("udr", 0);

    // 4: hold 8 entries, 40 concurrent cycles
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b0, 8'(8'h10 + i));
    flags("half", 8);
    for (int k = 0; k < 40; k++) begin
      cyc(1'b1, 1'b1, 8'(8'h18 + k));
      chk("wr_rd_dout", int'(dout), 8'h10 + k);
      chk("wr_rd_cnt", int'(count), 8);
    end

    // 5: top up to full (0x38..0x47), then wr&&rd
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b0, 8'(8'h40 + i));
    flags("top", 16);
    cyc(1'b1, 1'b1, 8'h55);
    chk("fwr_dout", int'(dout), 8'h38);
    chk("fwr_ovf", int'(overflow), 1);
    flags("fwr", 16);
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk("f55_dout", int'(dout), 8'h39 + i);
    end
    cyc(1'b0, 1'b1, 8'h00);
    chk("f55_last", int'(dout), 8'h55);
    flags("f55", 0);

    // 6: reset mid-stream
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b0, 8'(8'h60 + i));
    cyc(1'b0, 1'b1, 8'h00);
    chk("mid_dout", int'(dout), 8'h60);
    flags("mid", 7);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    flags("mrst", 0);
    chk("mrst_dout", int'(dout), 0);
    chk("mrst_ovf", int'(overflow), 0);
    chk("mrst_unf", int'(underflow), 0);
    cyc(1'b1, 1'b0, 8'h99);
    flags("post_wr", 1);
    cyc(1'b0, 1'b1, 8'h00);
    chk("post_dout", int'(dout), 8'h99);
    flags("post_rd", 0);
    chk("post_unf", int'(underflow), 0);

    // empty wr&&rd: write taken, read dropped
    cyc(1'b1, 1'b1, 8'h3C);
    flags("ewr", 1);
    chk("ewr_unf", int'(underflow), 1);
    chk("ewr_dout", int'(dout), 8'h99);
    cyc(1'b0, 1'b1, 8'h00);
    chk("ewr_rd", int'(dout), 8'h3C);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
